// File: rtl/execute_md.sv
// Execute stage: two-source forwarding, integer ALU and an iterative radix-2 mul/div unit with upstream stall.
// Optional: EXECUTE_MD_FAST_MUL_EN gives single-cycle multiplies; divides stay iterative.
module execute_md #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_flush,
  input  logic            id_ex__valid,
  input  logic [XLEN-1:0] id_ex__rs1_rdata,
  input  logic [XLEN-1:0] id_ex__rs2_rdata,
  input  logic [XLEN-1:0] id_ex__imm,
  input  logic [XLEN-1:0] id_ex__pc,
  input  logic [1:0]      id_ex__alu_a_src,
  input  logic            id_ex__alu_b_src,
  input  logic [3:0]      id_ex__alu_op,
  input  logic            id_ex__md_en,
  input  logic [2:0]      id_ex__md_op,
  input  logic [4:0]      id_ex__rs1_addr,
  input  logic [4:0]      id_ex__rs2_addr,
  input  logic [4:0]      ex_mb__rd_addr,
  input  logic [4:0]      mb_wb__rd_addr,
  input  logic            ex_mb__rd_wen,
  input  logic            mb_wb__rd_wen,
  input  logic [XLEN-1:0] wb_id__rd_wdata,
  output logic            ex_stall,
  output logic            ex_mb__valid,
  output logic [XLEN-1:0] ex_mb__alu_y,
  output logic            ex_mb__alu_zero,
  output logic [XLEN-1:0] ex_mb__pc,
  output logic [XLEN-1:0] ex_mb__pc_4,
  output logic [XLEN-1:0] ex_mb__rs1_rdata,
  output logic [XLEN-1:0] ex_mb__rs2_rdata
);
  localparam int SH_W = $clog2(XLEN);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SLT = 4'd3,
                         OP_SLTU = 4'd4, OP_XOR = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_OR = 4'd8, OP_AND = 4'd9, OP_PASSB = 4'd10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;

  logic [XLEN-1:0] rs1_fwd, rs2_fwd, alu_a, alu_b, alu_y;

  function automatic logic [XLEN-1:0] fwd(input logic [4:0] addr, input logic [XLEN-1:0] rf);
    if (ex_mb__rd_wen && ex_mb__rd_addr != 5'd0 && ex_mb__rd_addr == addr) return ex_mb__alu_y;
    if (mb_wb__rd_wen && mb_wb__rd_addr != 5'd0 && mb_wb__rd_addr == addr) return wb_id__rd_wdata;
    return rf;
  endfunction

  assign rs1_fwd = fwd(id_ex__rs1_addr, id_ex__rs1_rdata);
  assign rs2_fwd = fwd(id_ex__rs2_addr, id_ex__rs2_rdata);

  always_comb begin
    case (id_ex__alu_a_src)
      2'd0:    alu_a = '0;
      2'd1:    alu_a = id_ex__pc;
      2'd2:    alu_a = rs1_fwd;
      default: alu_a = '1;
    endcase
    alu_b = id_ex__alu_b_src ? rs2_fwd : id_ex__imm;
  end

  always_comb begin
    case (id_ex__alu_op)
      OP_ADD:   alu_y = alu_a + alu_b;
      OP_SUB:   alu_y = alu_a - alu_b;
      OP_SLL:   alu_y = alu_a << alu_b[SH_W-1:0];
      OP_SLT:   alu_y = XLEN'($signed(alu_a) < $signed(alu_b));
      OP_SLTU:  alu_y = XLEN'(alu_a < alu_b);
      OP_XOR:   alu_y = alu_a ^ alu_b;
      OP_SRL:   alu_y = alu_a >> alu_b[SH_W-1:0];
      OP_SRA:   alu_y = $signed(alu_a) >>> alu_b[SH_W-1:0];
      OP_OR:    alu_y = alu_a | alu_b;
      OP_AND:   alu_y = alu_a & alu_b;
      OP_PASSB: alu_y = alu_b;
      default:  alu_y = '0;
    endcase
  end

  // Operand sign handling: the datapath works on magnitudes, signs are re-applied in DONE.
  logic            a_sgn, b_sgn, a_neg, b_neg, accept;
  logic [XLEN-1:0] a_mag, b_mag;
  assign a_sgn  = (id_ex__md_op == 3'd1) | (id_ex__md_op == 3'd2) | (id_ex__md_op == 3'd4) | (id_ex__md_op == 3'd6);
  assign b_sgn  = (id_ex__md_op == 3'd1) | (id_ex__md_op == 3'd4) | (id_ex__md_op == 3'd6);
  assign a_neg  = a_sgn & rs1_fwd[XLEN-1];
  assign b_neg  = b_sgn & rs2_fwd[XLEN-1];
  assign a_mag  = a_neg ? -rs1_fwd : rs1_fwd;
  assign b_mag  = b_neg ? -rs2_fwd : rs2_fwd;
  assign accept = (state == IDLE) & id_ex__valid & id_ex__md_en & ~pipe_flush;
  assign ex_stall = ~pipe_flush & ((state == BUSY) | accept);

  logic [2:0]       op_q;
  logic             neg_q, aneg_q, dz_q;
  logic [XLEN-1:0]  opd_q, hi_q, lo_q, hi_nx, lo_nx;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN:0]    sum, shl, diff;

  // Multiply: {hi,lo} shift-add with lo holding the multiplier. Divide: restoring, hi = remainder, lo = quotient.
  always_comb begin
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    shl   = {hi_q, lo_q[XLEN-1]};
    diff  = shl - {1'b0, opd_q};
    hi_nx = sum[XLEN:1];
    lo_nx = {sum[0], lo_q[XLEN-1:1]};
    if (op_q[2]) begin
      hi_nx = diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
      lo_nx = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end
  end

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quot, remd, md_res;
  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? -prod : prod;
    quot   = dz_q ? '1 : (neg_q ? -lo_q : lo_q);
    remd   = aneg_q ? -hi_q : hi_q;
    case (op_q)
      3'd0:       md_res = prod_s[XLEN-1:0];
      3'd4, 3'd5: md_res = quot;
      3'd6, 3'd7: md_res = remd;
      default:    md_res = prod_s[2*XLEN-1:XLEN];
    endcase
  end

`ifdef EXECUTE_MD_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;  cnt_q <= '0;
      op_q <= '0;  neg_q <= 1'b0;  aneg_q <= 1'b0;  dz_q <= 1'b0;
      opd_q <= '0;  hi_q <= '0;  lo_q <= '0;
      ex_mb__valid <= 1'b0;  ex_mb__alu_y <= '0;  ex_mb__alu_zero <= 1'b0;
      ex_mb__rs1_rdata <= '0;  ex_mb__rs2_rdata <= '0;
      ex_mb__pc <= '1;  ex_mb__pc_4 <= '1;
    end else if (pipe_flush) begin
      state <= IDLE;  cnt_q <= '0;
      ex_mb__valid <= 1'b0;  ex_mb__pc <= '1;  ex_mb__pc_4 <= '1;
    end else begin
      ex_mb__pc        <= id_ex__pc;
      ex_mb__pc_4      <= id_ex__pc + XLEN'(4);
      ex_mb__rs1_rdata <= rs1_fwd;
      ex_mb__rs2_rdata <= rs2_fwd;
      case (state)
        IDLE: if (accept) begin
          op_q   <= id_ex__md_op;
          neg_q  <= a_neg ^ b_neg;
          aneg_q <= a_neg;
          dz_q   <= (rs2_fwd == '0);
          hi_q   <= '0;
          opd_q  <= id_ex__md_op[2] ? b_mag : a_mag;
          lo_q   <= id_ex__md_op[2] ? a_mag : b_mag;
          cnt_q  <= CNT_W'(XLEN);
          state  <= BUSY;
          ex_mb__valid <= 1'b0;
`ifdef EXECUTE_MD_FAST_MUL_EN
          if (!id_ex__md_op[2]) begin
            {hi_q, lo_q} <= fast_prod;
            cnt_q <= '0;
            state <= DONE;
          end
`endif
        end else begin
          ex_mb__valid    <= id_ex__valid;
          ex_mb__alu_y    <= alu_y;
          ex_mb__alu_zero <= (alu_y == '0);
        end
        BUSY: begin
          hi_q  <= hi_nx;
          lo_q  <= lo_nx;
          cnt_q <= cnt_q - CNT_W'(1);
          ex_mb__valid <= 1'b0;
          if (cnt_q == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          ex_mb__valid    <= 1'b1;
          ex_mb__alu_y    <= md_res;
          ex_mb__alu_zero <= (md_res == '0);
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md: scoreboard of expected EX/MB results, checked with immediate assertions.
module tb_execute_md;
  localparam int XLEN = 32;
`ifdef EXECUTE_MD_FAST_MUL_EN
  localparam int MUL_STALL = 1;
`else
  localparam int MUL_STALL = XLEN + 1;
`endif
  localparam int DIV_STALL = XLEN + 1;

  logic            clk, rst_n, pipe_flush, id_ex__valid, id_ex__alu_b_src, id_ex__md_en;
  logic [XLEN-1:0] id_ex__rs1_rdata, id_ex__rs2_rdata, id_ex__imm, id_ex__pc, wb_id__rd_wdata;
  logic [1:0]      id_ex__alu_a_src;
  logic [3:0]      id_ex__alu_op;
  logic [2:0]      id_ex__md_op;
  logic [4:0]      id_ex__rs1_addr, id_ex__rs2_addr, ex_mb__rd_addr, mb_wb__rd_addr;
  logic            ex_mb__rd_wen, mb_wb__rd_wen;
  logic            ex_stall, ex_mb__valid, ex_mb__alu_zero;
  logic [XLEN-1:0] ex_mb__alu_y, ex_mb__pc, ex_mb__pc_4, ex_mb__rs1_rdata, ex_mb__rs2_rdata;

  int n_assert = 0;
  int n_fail   = 0;
  logic [XLEN-1:0] sb_q[$];

  execute_md #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush), .id_ex__valid(id_ex__valid),
    .id_ex__rs1_rdata(id_ex__rs1_rdata), .id_ex__rs2_rdata(id_ex__rs2_rdata),
    .id_ex__imm(id_ex__imm), .id_ex__pc(id_ex__pc), .id_ex__alu_a_src(id_ex__alu_a_src),
    .id_ex__alu_b_src(id_ex__alu_b_src), .id_ex__alu_op(id_ex__alu_op), .id_ex__md_en(id_ex__md_en),
    .id_ex__md_op(id_ex__md_op), .id_ex__rs1_addr(id_ex__rs1_addr), .id_ex__rs2_addr(id_ex__rs2_addr),
    .ex_mb__rd_addr(ex_mb__rd_addr), .mb_wb__rd_addr(mb_wb__rd_addr), .ex_mb__rd_wen(ex_mb__rd_wen),
    .mb_wb__rd_wen(mb_wb__rd_wen), .wb_id__rd_wdata(wb_id__rd_wdata), .ex_stall(ex_stall),
    .ex_mb__valid(ex_mb__valid), .ex_mb__alu_y(ex_mb__alu_y), .ex_mb__alu_zero(ex_mb__alu_zero),
    .ex_mb__pc(ex_mb__pc), .ex_mb__pc_4(ex_mb__pc_4), .ex_mb__rs1_rdata(ex_mb__rs1_rdata),
    .ex_mb__rs2_rdata(ex_mb__rs2_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_compare(input string tag);
    logic [XLEN-1:0] e;
    e = 'x;
    if (sb_q.size() != 0) e = sb_q.pop_front();
    chk({tag, "_valid"}, 64'(ex_mb__valid), 64'd1);
    chk(tag, 64'(ex_mb__alu_y), 64'(e));
  endtask

  task automatic quiet_inputs();
    id_ex__valid = 1'b0;  id_ex__md_en = 1'b0;  id_ex__md_op = 3'd0;  pipe_flush = 1'b0;
    id_ex__alu_a_src = 2'd0;  id_ex__alu_b_src = 1'b0;  id_ex__alu_op = 4'd0;
    id_ex__rs1_rdata = '0;  id_ex__rs2_rdata = '0;  id_ex__imm = '0;  id_ex__pc = 32'h1000;
    id_ex__rs1_addr = 5'd1;  id_ex__rs2_addr = 5'd2;  ex_mb__rd_addr = 5'd0;  mb_wb__rd_addr = 5'd0;
    ex_mb__rd_wen = 1'b0;  mb_wb__rd_wen = 1'b0;  wb_id__rd_wdata = '0;
  endtask

  // Called at a negedge; leaves time at the next negedge with the result registered.
  task automatic alu_step(input string tag, input logic [1:0] asrc, input logic bsrc, input logic [3:0] op,
                          input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2, input logic [XLEN-1:0] imm,
                          input logic [XLEN-1:0] exp);
    id_ex__valid = 1'b1;  id_ex__md_en = 1'b0;  id_ex__alu_a_src = asrc;  id_ex__alu_b_src = bsrc;
    id_ex__alu_op = op;  id_ex__rs1_rdata = r1;  id_ex__rs2_rdata = r2;  id_ex__imm = imm;
    sb_q.push_back(exp);
    #1 chk({tag, "_stall"}, 64'(ex_stall), 64'd0);
    @(negedge clk);
    sb_compare(tag);
  endtask

  task automatic md_step(input string tag, input logic [2:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int stl);
    int n;
    bit done;
    id_ex__valid = 1'b1;  id_ex__md_en = 1'b1;  id_ex__md_op = op;
    id_ex__rs1_rdata = a;  id_ex__rs2_rdata = b;
    sb_q.push_back(exp);
    n = 0;  done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (ex_stall) begin n++; @(negedge clk); end
      else done = 1'b1;
    end
    chk({tag, "_stall_cycles"}, 64'(n), 64'(stl));
    @(negedge clk);
    chk({tag, "_zero"}, 64'(ex_mb__alu_zero), 64'(exp == '0));
    sb_compare(tag);
    id_ex__valid = 1'b0;  id_ex__md_en = 1'b0;
  endtask

  initial begin
    int vcnt;
    quiet_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stall", 64'(ex_stall), 64'd0);
    chk("rst_valid", 64'(ex_mb__valid), 64'd0);
    chk("rst_alu_y", 64'(ex_mb__alu_y), 64'd0);
    chk("rst_zero", 64'(ex_mb__alu_zero), 64'd0);
    chk("rst_pc", 64'(ex_mb__pc), 64'hFFFF_FFFF);
    chk("rst_pc_4", 64'(ex_mb__pc_4), 64'hFFFF_FFFF);
    rst_n = 1'b1;

    // ALU path and forwarding
    id_ex__pc = 32'h100;
    alu_step("add_imm", 2'd0, 1'b0, 4'd0, 32'd0, 32'd0, 32'd100, 32'd100);
    chk("pc", 64'(ex_mb__pc), 64'h100);
    chk("pc_4", 64'(ex_mb__pc_4), 64'h104);
    id_ex__rs1_addr = 5'd3;  id_ex__rs2_addr = 5'd4;
    ex_mb__rd_addr = 5'd3;  ex_mb__rd_wen = 1'b1;
    mb_wb__rd_addr = 5'd3;  mb_wb__rd_wen = 1'b1;  wb_id__rd_wdata = 32'd55;
    alu_step("fwd_exmb", 2'd2, 1'b1, 4'd0, 32'd5, 32'd7, 32'd0, 32'd107);
    chk("fwd_rs1_out", 64'(ex_mb__rs1_rdata), 64'd100);
    chk("fwd_rs2_out", 64'(ex_mb__rs2_rdata), 64'd7);
    ex_mb__rd_wen = 1'b0;  mb_wb__rd_addr = 5'd4;  wb_id__rd_wdata = 32'd20;
    alu_step("fwd_mbwb", 2'd2, 1'b1, 4'd0, 32'd5, 32'd7, 32'd0, 32'd25);
    mb_wb__rd_wen = 1'b0;  ex_mb__rd_wen = 1'b1;  ex_mb__rd_addr = 5'd0;  id_ex__rs1_addr = 5'd0;
    alu_step("x0_nofwd", 2'd2, 1'b0, 4'd0, 32'd9, 32'd0, 32'd1, 32'd10);
    ex_mb__rd_wen = 1'b0;  id_ex__rs1_addr = 5'd1;  id_ex__rs2_addr = 5'd2;
    alu_step("ones_plus1", 2'd3, 1'b0, 4'd0, 32'd0, 32'd0, 32'd1, 32'd0);
    chk("ones_plus1_zero", 64'(ex_mb__alu_zero), 64'd1);
    alu_step("sub", 2'd2, 1'b1, 4'd1, 32'd5, 32'd7, 32'd0, 32'hFFFF_FFFE);
    id_ex__valid = 1'b0;

    // Multiply / divide, issued back to back
    md_step("mul", 3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, MUL_STALL);
    md_step("mulhu", 3'd3, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, MUL_STALL);
    md_step("mulh", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_STALL);
    md_step("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_STALL);
    md_step("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_STALL);
    md_step("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, DIV_STALL);
    md_step("divu_z", 3'd5, 32'd7, 32'd0, 32'hFFFF_FFFF, DIV_STALL);
    md_step("remu_z", 3'd7, 32'd7, 32'd0, 32'd7, DIV_STALL);
    md_step("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_STALL);
    md_step("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_STALL);
    md_step("div_z_sgn", 3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, DIV_STALL);

    // Flush in the middle of a divide
    id_ex__valid = 1'b1;  id_ex__md_en = 1'b1;  id_ex__md_op = 3'd4;
    id_ex__rs1_rdata = 32'd100;  id_ex__rs2_rdata = 32'd3;
    repeat (10) @(negedge clk);
    pipe_flush = 1'b1;
    #1 chk("flush_stall", 64'(ex_stall), 64'd0);
    @(negedge clk);
    chk("flush_valid", 64'(ex_mb__valid), 64'd0);
    chk("flush_pc", 64'(ex_mb__pc), 64'hFFFF_FFFF);
    chk("flush_pc_4", 64'(ex_mb__pc_4), 64'hFFFF_FFFF);
    pipe_flush = 1'b0;  id_ex__valid = 1'b0;  id_ex__md_en = 1'b0;
    md_step("mul_after_flush", 3'd0, 32'h1234_5678, 32'h10, 32'h2345_6780, MUL_STALL);

    // Reset in the middle of a divide
    id_ex__valid = 1'b1;  id_ex__md_en = 1'b1;  id_ex__md_op = 3'd5;
    id_ex__rs1_rdata = 32'd1000;  id_ex__rs2_rdata = 32'd7;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;  id_ex__valid = 1'b0;  id_ex__md_en = 1'b0;
    @(negedge clk);
    chk("mrst_stall", 64'(ex_stall), 64'd0);
    chk("mrst_valid", 64'(ex_mb__valid), 64'd0);
    chk("mrst_alu_y", 64'(ex_mb__alu_y), 64'd0);
    chk("mrst_rs1", 64'(ex_mb__rs1_rdata), 64'd0);
    chk("mrst_rs2", 64'(ex_mb__rs2_rdata), 64'd0);
    chk("mrst_pc", 64'(ex_mb__pc), 64'hFFFF_FFFF);
    rst_n = 1'b1;
    vcnt = 0;
    for (int i = 0; i < XLEN + 5; i++) begin
      @(negedge clk);
      if (ex_mb__valid || ex_stall) vcnt++;
    end
    chk("mrst_discarded", 64'(vcnt), 64'd0);
    md_step("mul_3x4", 3'd0, 32'd3, 32'd4, 32'd12, MUL_STALL);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/execute_md.md
Name: execute_md

Overview:
- Parametrised successor of the pipeline execute stage. Generalised to XLEN-wide operands.
- Keeps the two-source (EX/MB, MB/WB) operand forwarding and the int_alu path.
- Adds an iterative multiply/divide unit (RV32M/RV64M funct3 set) with a stall handshake to the upstream pipeline.
- Sits between the ID/EX and EX/MB pipeline registers; drives ex_stall back to fetch/decode.

Parameters:
- XLEN, 32, datapath width (32 or 64).
- CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- pipe_flush  in  1  kill the instruction in EX and abort any mul/div.
- id_ex__valid  in  1  EX holds a real instruction.
- id_ex__rs1_rdata, id_ex__rs2_rdata, id_ex__imm, id_ex__pc  in  XLEN each  operands, immediate and PC from decode.
- id_ex__alu_a_src  in  2  operand-A select: ZERO / PC / RS1.
- id_ex__alu_b_src  in  1  operand-B select: IMM / RS2.
- id_ex__alu_op  in  4  int_alu operation.
- id_ex__md_en  in  1  instruction is a mul/div.
- id_ex__md_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- id_ex__rs1_addr, id_ex__rs2_addr, ex_mb__rd_addr, mb_wb__rd_addr  in  5 each  forwarding addresses.
- ex_mb__rd_wen, mb_wb__rd_wen  in  1 each  destination write enables.
- wb_id__rd_wdata  in  XLEN  writeback data.
- ex_stall  out  1  upstream must hold the ID/EX registers and PC.
- ex_mb__valid  out  1  EX/MB holds a real instruction.
- ex_mb__alu_y  out  XLEN  ALU or mul/div result.
- ex_mb__alu_zero  out  1  ALU zero flag.
- ex_mb__pc, ex_mb__pc_4  out  XLEN each  PC and PC+4.
- ex_mb__rs1_rdata, ex_mb__rs2_rdata  out  XLEN each  forwarded operands.

Behaviour:
- Forwarding (combinational):
  - EX/MB match when rd_addr != 0, rd_wen = 1 and addresses are equal; EX/MB beats MB/WB, which beats the register file.
  - The EX/MB source is ex_mb__alu_y.
- Operand muxes: alu_a_src 0 gives zero, 1 gives PC, 2 gives RS1, 3 gives all-ones. alu_b_src 0 gives imm, 1 gives RS2.
- Non-md instruction: registered into EX/MB with 1-cycle latency, as in the prior execute stage.
  - ex_mb__valid <= id_ex__valid & ~pipe_flush.
- MD state machine: IDLE, BUSY, DONE.
  - IDLE, with id_ex__valid & md_en & ~pipe_flush:
    - latch forwarded rs1/rs2 magnitudes, sign-fix flags and md_op;
    - counter <= XLEN; go to BUSY;
    - ex_stall = 1 in that same cycle (combinational); ex_mb__valid <= 0.
  - BUSY: one radix-2 iteration per cycle (shift-add multiply, restoring divide); counter decrements; ex_stall = 1; ex_mb__valid <= 0. When counter reaches 1, go to DONE.
  - DONE: ex_stall = 0; apply sign fix-up.
    - MUL: low XLEN bits.
    - MULH/MULHSU/MULHU: high XLEN bits.
    - DIV/DIVU: quotient; REM/REMU: remainder.
    - ex_mb__alu_y <= result, ex_mb__valid <= 1, pc and pc_4 registered normally, ex_mb__alu_zero <= (result == 0). Go to IDLE.
  - Total EX occupancy XLEN+2 cycles; ex_stall high XLEN+1 cycles.
- Operands are frozen at accept: later writebacks never change an in-flight op.
- Divide by zero: quotient all-ones; remainder = dividend.
- Signed overflow (most-negative / -1): quotient = most-negative; remainder = 0.
- pipe_flush in any state:
  - state <= IDLE, counter <= 0; ex_stall = 0 that same cycle;
  - ex_mb__valid <= 0; ex_mb__pc and ex_mb__pc_4 <= all-ones.
  - Flush wins over a same-cycle accept.
- Reset (rst_n = 0 at an edge):
  - state IDLE, counter 0, ex_stall 0, ex_mb__valid 0;
  - ex_mb__alu_y, ex_mb__rs1_rdata, ex_mb__rs2_rdata 0; ex_mb__alu_zero 0;
  - ex_mb__pc and ex_mb__pc_4 all-ones.
  - Reset mid-operation discards the op.
- Back-to-back md ops: the second one is accepted in the cycle after DONE (IDLE), with no lost cycle beyond the DONE cycle.

Optional Feature:
- EXECUTE_MD_FAST_MUL_EN
  - Defined: MUL/MULH/MULHSU/MULHU use a single-cycle combinational 2*XLEN multiplier. IDLE goes straight to DONE: ex_stall high 1 cycle, EX occupancy 2 cycles. Divides are unchanged.
  - Undefined: all md ops are iterative, as above.

Test Plan:
- ADD, rs1=5, rs2=7, ex_mb__rd_addr=rs1 holding alu_y=100 -> ex_mb__alu_y=107 the next cycle; ex_stall stays 0.
- MUL 0xFFFFFFFF x 2 (XLEN=32) -> stall for 33 cycles, then alu_y=0xFFFFFFFE and valid=1. MULHU on the same operands -> 0x00000001. MULH -> 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0. DIVU 7 / 0 -> 0xFFFFFFFF; REMU 7 / 0 -> 7.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF.
- pipe_flush at BUSY cycle 10 -> ex_stall drops the same cycle; ex_mb__valid=0; ex_mb__pc=0xFFFFFFFF. The next MUL completes correctly.
- rst_n low during BUSY, then high -> IDLE with all outputs at reset values. With EXECUTE_MD_FAST_MUL_EN, MUL 3 x 4 -> 1-cycle stall, then alu_y=12.
